// File: rtl/ps2_kb_rx_pkg.sv
// Shared constants for the PS/2 keyboard receiver: scan-code width, FIFO depth default
// and the 2-bit deframer state encodings.
package ps2_kb_rx_pkg;

  localparam int KbWidth      = 8;
  localparam int FifoDepthDef = 8;

  localparam logic [1:0] Ps2Idle   = 2'd0;
  localparam logic [1:0] Ps2Data   = 2'd1;
  localparam logic [1:0] Ps2Parity = 2'd2;
  localparam logic [1:0] Ps2Stop   = 2'd3;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 line synchronisers, falling-edge detect and 11-bit frame deframer.
// Optional partial-frame timeout enabled by defining PS2_TIMEOUT_EN.
import ps2_kb_rx_pkg::*;

module ps2_frame_rx #(
  parameter int KB_WIDTH       = KbWidth,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ps2_clk,
  input  logic                ps2_data,
  output logic [KB_WIDTH-1:0] frameByte,
  output logic                byteVld,
  output logic                frameErr
);

  localparam int CntW = $clog2(KB_WIDTH);

  if (TIMEOUT_CYCLES < 2) begin : gBadTimeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  function automatic logic oddParityOk(input logic [KB_WIDTH-1:0] d, input logic p);
    return ^{d, p};
  endfunction

  logic ps2Clk_p0, ps2Clk_p1, ps2Clk_p2;
  logic ps2Data_p0, ps2Data_p1;
  logic fallEdge;
  logic [1:0] state;
  logic [CntW-1:0] bitCnt;
  logic [KB_WIDTH-1:0] shReg;
  logic parOk;
  logic toHit;

  // synchroniser stages: lines idle high, so reset fills them with 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps2Clk_p0  <= 1'b1;
      ps2Clk_p1  <= 1'b1;
      ps2Clk_p2  <= 1'b1;
      ps2Data_p0 <= 1'b1;
      ps2Data_p1 <= 1'b1;
    end else begin
      ps2Clk_p0  <= ps2_clk;
      ps2Clk_p1  <= ps2Clk_p0;
      ps2Clk_p2  <= ps2Clk_p1;
      ps2Data_p0 <= ps2_data;
      ps2Data_p1 <= ps2Data_p0;
    end
  end

  assign fallEdge = ps2Clk_p2 & ~ps2Clk_p1;

`ifdef PS2_TIMEOUT_EN
  localparam int ToW = $clog2(TIMEOUT_CYCLES);
  logic [ToW-1:0] toCnt;

  assign toHit = (state != Ps2Idle) && !fallEdge && (toCnt == ToW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      toCnt <= '0;
    end else if (state == Ps2Idle || fallEdge || toHit) begin
      toCnt <= '0;
    end else begin
      toCnt <= toCnt + 1'b1;
    end
  end
`else
  assign toHit = 1'b0;
`endif

  // deframer: one transition per detected falling edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= Ps2Idle;
      bitCnt   <= '0;
      shReg    <= '0;
      parOk    <= 1'b0;
      byteVld  <= 1'b0;
      frameErr <= 1'b0;
    end else begin
      byteVld  <= 1'b0;
      frameErr <= 1'b0;
      if (toHit) begin
        state    <= Ps2Idle;
        frameErr <= 1'b1;
      end else if (fallEdge) begin
        case (state)
          Ps2Idle: begin
            if (!ps2Data_p1) begin
              state  <= Ps2Data;
              bitCnt <= '0;
            end else begin
              frameErr <= 1'b1;
            end
          end
          Ps2Data: begin
            shReg  <= {ps2Data_p1, shReg[KB_WIDTH-1:1]};
            bitCnt <= bitCnt + 1'b1;
            if (bitCnt == CntW'(KB_WIDTH - 1)) state <= Ps2Parity;
          end
          Ps2Parity: begin
            parOk <= oddParityOk(shReg, ps2Data_p1);
            state <= Ps2Stop;
          end
          default: begin
            if (ps2Data_p1 && parOk) byteVld  <= 1'b1;
            else                     frameErr <= 1'b1;
            state <= Ps2Idle;
          end
        endcase
      end
    end
  end

  assign frameByte = shReg;

endmodule

// File: rtl/ps2_kb_rx.sv
// PS/2 keyboard receiver top: deframer plus first-word-fall-through scan-code FIFO.
// Define PS2_TIMEOUT_EN to abort stalled partial frames after TIMEOUT_CYCLES.
import ps2_kb_rx_pkg::*;

module ps2_kb_rx #(
  parameter int FIFO_DEPTH     = FifoDepthDef,
  parameter int KB_WIDTH       = KbWidth,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ps2_clk,
  input  logic                ps2_data,
  input  logic                kb_rd,
  output logic [KB_WIDTH-1:0] kb_data,
  output logic                kb_ready,
  output logic                overflow,
  output logic                frame_err
);

  localparam int AddrW = $clog2(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || (1 << AddrW) != FIFO_DEPTH) begin : gBadDepth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end

  logic [KB_WIDTH-1:0] frameByte;
  logic                byteVld;
  logic                frameErr;

  ps2_frame_rx #(
    .KB_WIDTH      (KB_WIDTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) uFrame (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .frameByte(frameByte),
    .byteVld  (byteVld),
    .frameErr (frameErr)
  );

  logic [KB_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AddrW:0]      wrPtr, rdPtr;
  logic [AddrW-1:0]    headIdx;
  logic                empty, full, doPop, doPush;

  assign empty  = (wrPtr == rdPtr);
  assign full   = (wrPtr[AddrW] != rdPtr[AddrW]) && (wrPtr[AddrW-1:0] == rdPtr[AddrW-1:0]);
  assign doPop  = kb_rd && !empty;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign doPush = byteVld && (!full || doPop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (doPush) begin
      mem[wrPtr[AddrW-1:0]] <= frameByte;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      overflow <= 1'b0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      if (byteVld && !doPush) overflow <= 1'b1;
    end
  end

  // when empty, show the slot that was read last rather than the next write slot
  assign headIdx   = empty ? (rdPtr[AddrW-1:0] - 1'b1) : rdPtr[AddrW-1:0];
  assign kb_data   = mem[headIdx];
  assign kb_ready  = !empty;
  assign frame_err = frameErr;

endmodule
